cache_mem_arbiter: RTL and testbench

Shares the single 128-bit line-wide memory port between NUM_REQ cache controllers (e.g. I-cache and D-cache).
- Each requester presents the same memory handshake the cache controller drives: addr, 128-bit line, rw, valid/ready.
- Arbitration is round-robin with the grant locked for one full transaction.
- Sits between the cache controllers' memory interfaces and the memory model or bus.

---
 rtl/cache_pkg.sv | 15 +
 rtl/rr_picker.sv | 28 ++
 rtl/cache_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types for the cache memory-side arbiter.
// Line width and address width match the cache controllers.
package cache_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Searches upward from last+1 with wrap-around.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant,
  output logic          any_req
);

  int idx;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port.
// Optional MEM_ARB_TIMEOUT_EN adds a BUSY watchdog and arb_timeout.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*LINE_W-1:0]   req_dataout,
  input  logic [NUM_REQ-1:0]          req_rw,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [LINE_W-1:0]           req_datain,
  output logic [ADDR_W-1:0]           mem_req_addr,
  output logic [LINE_W-1:0]           mem_req_dataout,
  output logic                        mem_req_rw,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  input  logic [LINE_W-1:0]           mem_req_datain,
  output logic [$clog2(NUM_REQ)-1:0]  arb_owner
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic                        arb_timeout
`endif
);

  localparam int OW = $clog2(NUM_REQ);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  line_t             data_q, data_d;
  logic              rw_q, rw_d;
  logic              valid_q, valid_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     last_q, last_d;
  logic [OW-1:0]     grant;
  logic              any_req;
  logic              expire;

  rr_picker #(
    .N  (NUM_REQ),
    .IW (OW)
  ) u_pick (
    .req     (req_valid),
    .last    (last_q),
    .grant   (grant),
    .any_req (any_req)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;

  assign expire = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // counts BUSY cycles; cleared on every grant
  always_comb begin
    cnt_d = cnt_q;
    tmo_d = 1'b0;
    if (state_q == ARB_IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
      tmo_d = !mem_req_ready && expire;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign arb_timeout = tmo_q;
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    valid_d = valid_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          addr_d  = req_addr[ADDR_W*int'(grant) +: ADDR_W];
          data_d  = req_dataout[LINE_W*int'(grant) +: LINE_W];
          rw_d    = req_rw[grant];
          owner_d = grant;
          last_d  = grant;
          valid_d = 1'b1;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (mem_req_ready || expire) begin
          valid_d = 1'b0;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // completion is routed only to the locked owner
  always_comb begin
    req_ready = '0;
    if (state_q == ARB_BUSY) begin
      req_ready[owner_q] = mem_req_ready;
    end
  end

  assign req_datain      = mem_req_datain;
  assign mem_req_addr    = addr_q;
  assign mem_req_dataout = data_q;
  assign mem_req_rw      = rw_q;
  assign mem_req_valid   = valid_q;
  assign arb_owner       = owner_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter (NUM_REQ=2).
// Covers MEM_ARB_TIMEOUT_EN when that macro is defined.
module tb_cache_mem_arbiter;
  import cache_pkg::*;

  typedef struct {
    int          owner;
    logic [31:0] addr;
    logic        rw;
    line_t       data;
  } gexp_t;

  typedef struct {
    logic [1:0] rdy;
    line_t      data;
  } cexp_t;

  logic         clk;
  logic         rst_n;
  logic [63:0]  req_addr;
  logic [255:0] req_dataout;
  logic [1:0]   req_rw;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  line_t        req_datain;
  logic [31:0]  mem_req_addr;
  line_t        mem_req_dataout;
  logic         mem_req_rw;
  logic         mem_req_valid;
  logic         mem_req_ready;
  line_t        mem_req_datain;
  logic [0:0]   arb_owner;
`ifdef MEM_ARB_TIMEOUT_EN
  logic         arb_timeout;
`endif

  logic [31:0] ra [2];
  line_t       rd [2];
  logic        rr [2];

  gexp_t gq[$];
  cexp_t cq[$];
  int checks = 0;
  int errors = 0;
  int rc0 = 0;
  int rc1 = 0;

  assign req_addr    = {ra[1], ra[0]};
  assign req_dataout = {rd[1], rd[0]};
  assign req_rw      = {rr[1], rr[0]};

  cache_mem_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_addr        (req_addr),
    .req_dataout     (req_dataout),
    .req_rw          (req_rw),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_datain      (req_datain),
    .mem_req_addr    (mem_req_addr),
    .mem_req_dataout (mem_req_dataout),
    .mem_req_rw      (mem_req_rw),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_datain  (mem_req_datain),
    .arb_owner       (arb_owner)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .arb_timeout     (arb_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a,
                         input logic r, input line_t d);
    ra[i] = a;
    rr[i] = r;
    rd[i] = d;
  endtask

  task automatic push_g(input int who);
    gexp_t g;
    g.owner = who;
    g.addr  = ra[who];
    g.rw    = rr[who];
    g.data  = rd[who];
    gq.push_back(g);
  endtask

  task automatic push_c(input int who, input line_t d);
    cexp_t c;
    c.rdy  = (who == 0) ? 2'b01 : 2'b10;
    c.data = d;
    cq.push_back(c);
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (!mem_req_valid && n < 50) begin
      cyc();
      n++;
    end
    if (!mem_req_valid) begin
      checks++;
      errors++;
      $display("FAIL grant_wait got=no_grant exp=grant");
    end
  endtask

  task automatic complete(input line_t d);
    mem_req_datain = d;
    mem_req_ready  = 1'b1;
    cyc();
    mem_req_ready  = 1'b0;
    mem_req_datain = '0;
  endtask

  task automatic txn(input int who, input int lat, input line_t d,
                     output int n);
    push_g(who);
    push_c(who, d);
    wait_grant(n);
    repeat (lat) cyc();
    complete(d);
  endtask

  initial begin : mon
    bit    pv;
    gexp_t g;
    cexp_t c;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        continue;
      end
      if (mem_req_valid && !pv) begin
        if (gq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant_extra got=owner%0d exp=none", arb_owner);
        end else begin
          g = gq.pop_front();
          chk("grant_owner", 128'(arb_owner), 128'(g.owner));
          chk("grant_addr", 128'(mem_req_addr), 128'(g.addr));
          chk("grant_rw", 128'(mem_req_rw), 128'(g.rw));
          chk("grant_data", mem_req_dataout, g.data);
        end
      end
      pv = mem_req_valid;
      if (req_ready != 2'b00) begin
        if (req_ready[0]) rc0++;
        if (req_ready[1]) rc1++;
        if (cq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ready_extra got=%b exp=00", req_ready);
        end else begin
          c = cq.pop_front();
          chk("ready_vec", 128'(req_ready), 128'(c.rdy));
          chk("ready_data", req_datain, c.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "bench did not terminate");
  end

  initial begin : stim
    int n;
    int s0;
    int s1;
    rst_n          = 1'b0;
    req_valid      = 2'b00;
    mem_req_ready  = 1'b0;
    mem_req_datain = '0;
    set_req(0, 32'h0, 1'b0, '0);
    set_req(1, 32'h0, 1'b0, '0);
    #3;
    chk("rst_valid", 128'(mem_req_valid), 128'(0));
    chk("rst_ready", 128'(req_ready), 128'(0));
    chk("rst_owner", 128'(arb_owner), 128'(0));
    chk("rst_addr", 128'(mem_req_addr), 128'(0));
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // single read
    set_req(0, 32'h0000_1000, 1'b0, '0);
    req_valid = 2'b01;
    txn(0, 2, 128'hAAAA_AAAA_BBBB_BBBB_CCCC_CCCC_DDDD_DDDD, n);
    chk("t1_grant_lat", 128'(n), 128'(1));
    req_valid = 2'b00;
    cyc();

    // simultaneous from reset
    rst_n = 1'b0;
    set_req(0, 32'h0000_1000, 1'b0, 128'h0);
    set_req(1, 32'h0000_2000, 1'b1,
            128'h1111_1111_2222_2222_3333_3333_4444_4444);
    req_valid = 2'b11;
    cyc();
    rst_n = 1'b1;
    txn(0, 1, 128'hCAFE_0000_0000_0000_0000_0000_0000_BEEF, n);
    req_valid[0] = 1'b0;
    txn(1, 2, 128'h0, n);
    req_valid[1] = 1'b0;
    cyc();

    // fairness
    set_req(0, 32'h0000_3000, 1'b0, 128'h0);
    set_req(1, 32'h0000_4000, 1'b1, 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC);
    s0 = rc0;
    s1 = rc1;
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      txn(i % 2, 0, 128'(i + 16'h0F00), n);
    end
    req_valid = 2'b00;
    cyc();
    cyc();
    chk("t3_cnt0", 128'(rc0 - s0), 128'(3));
    chk("t3_cnt1", 128'(rc1 - s1), 128'(3));

    // stray mem_req_ready in IDLE
    mem_req_datain = 128'h1234;
    mem_req_ready  = 1'b1;
    #1;
    chk("t4_stray_rdy", 128'(req_ready), 128'(0));
    cyc();
    mem_req_ready  = 1'b0;
    mem_req_datain = '0;
    chk("t4_idle_valid", 128'(mem_req_valid), 128'(0));
    cyc();
    chk("t4_idle_valid2", 128'(mem_req_valid), 128'(0));

    // late request on completion cycle
    set_req(0, 32'h0000_5000, 1'b0, 128'h0);
    set_req(1, 32'h0000_6000, 1'b0, 128'h0);
    req_valid = 2'b01;
    push_g(0);
    push_c(0, 128'h77);
    wait_grant(n);
    cyc();
    req_valid[1] = 1'b1;
    complete(128'h77);
    req_valid[0] = 1'b0;
    chk("t4_turnaround", 128'(mem_req_valid), 128'(0));
    txn(1, 0, 128'h88, n);
    chk("t4_late_lat", 128'(n), 128'(1));
    req_valid = 2'b00;
    cyc();

    // reset while BUSY
    set_req(0, 32'h0000_7000, 1'b0, 128'h0);
    set_req(1, 32'h0000_8000, 1'b0, 128'h0);
    req_valid = 2'b01;
    push_g(0);
    wait_grant(n);
    @(negedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("t5_async_valid", 128'(mem_req_valid), 128'(0));
    chk("t5_async_ready", 128'(req_ready), 128'(0));
    cyc();
    cyc();
    rst_n = 1'b1;
    txn(0, 1, 128'h99, n);
    req_valid = 2'b00;
    cyc();
    cyc();

`ifdef MEM_ARB_TIMEOUT_EN
    set_req(0, 32'h0000_9000, 1'b0, 128'h0);
    set_req(1, 32'h0000_A000, 1'b0, 128'h0);
    req_valid = 2'b11;
    push_g(0);
    wait_grant(n);
    n = 0;
    while (!arb_timeout && n < 20) begin
      cyc();
      n++;
    end
    chk("t6_tmo_cycles", 128'(n), 128'(8));
    req_valid[0] = 1'b0;
    txn(1, 0, 128'hAB, n);
    chk("t6_next_lat", 128'(n), 128'(1));
    req_valid = 2'b00;
    cyc();
    cyc();
`endif

    repeat (3) cyc();
    chk("gq_empty", 128'(gq.size()), 128'(0));
    chk("cq_empty", 128'(cq.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
